// File: rtl/seg_key_pkg.sv
// Shared constants for the button / seven-segment bus responder.
// Address offsets are relative to the peripheral base address.
package seg_key_pkg;

    localparam logic [31:0] OFF_KEYSTAT = 32'h0000_0000;
    localparam logic [31:0] OFF_SEG0    = 32'h0000_0010;
    localparam logic [31:0] OFF_SEG1    = 32'h0000_0014;
    localparam logic [31:0] OFF_SEG2    = 32'h0000_0018;

    localparam int MAX_DIGITS = 12;
    localparam int SEG_WORDS  = (MAX_DIGITS + 3) / 4;

    localparam logic [SEG_WORDS-1:0][31:0] SEG_OFFS =
        {OFF_SEG2, OFF_SEG1, OFF_SEG0};

    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Word match: byte-lane bits [1:0] are don't-care on both sides.
    function automatic logic wordHit(
        input logic [31:0] addr,
        input logic [31:0] target
    );
        return (addr | 32'h3) == (target | 32'h3);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One push button: two-flop synchronizer followed by a
// stability counter that flips the accepted level.
module key_debounce
    import seg_key_pkg::*;
#(
    parameter int DEBOUNCE = 16
) (
    input  logic wClk,
    input  logic nwReset,
    input  logic wRaw,
    output logic wKey
);

    localparam int CW = $clog2(DEBOUNCE);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge wClk or negedge nwReset) begin
        if (!nwReset) begin
            sync <= 2'b00;
            cnt  <= '0;
            wKey <= 1'b0;
        end else begin
            sync <= {sync[0], wRaw};
            if (sync[1] == wKey) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                wKey <= ~wKey;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_key_responder.sv
// Bus target for key status and segment registers, plus the
// multiplexed display scanner driving one digit at a time.
module seg_key_responder
    import seg_key_pkg::*;
#(
    parameter int          KEYS     = 3,
    parameter int          DIGITS   = 10,
    parameter logic [31:0] BASEADDR = 32'hF000_0000,
    parameter int          DEBOUNCE = 16,
    parameter int          SCANDIV  = 1000
) (
    input  logic              wClk,
    input  logic              nwReset,
    input  logic              wWrite,
    input  logic [31:0]       bWriteAddr,
    input  logic [31:0]       bWriteData,
    input  logic [3:0]        bWriteMask,
    input  logic              wRead,
    input  logic [31:0]       bReadAddr,
    output logic [31:0]       bReadData,
    input  logic [KEYS-1:0]   bKeyRaw,
    output logic [7:0]        bSegOut,
    output logic [DIGITS-1:0] bDigitSel
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DW = $clog2(SCANDIV);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCANDIV - 1);

    logic [KEYS-1:0]             keyState;
    logic [DIGITS-1:0][7:0]      segReg;
    logic [SEG_WORDS-1:0][31:0]  segWords;
    logic [SEG_WORDS-1:0]        wrHit;
    logic [SEG_WORDS-1:0]        rdHit;
    logic                        rdHitKey;
    logic [31:0]                 rdWord;
    logic [DW-1:0]               divCnt;
    logic [IW-1:0]               digitIdx;

    for (genvar k = 0; k < KEYS; k++) begin : gKey
        key_debounce #(
            .DEBOUNCE(DEBOUNCE)
        ) uDebounce (
            .wClk    (wClk),
            .nwReset (nwReset),
            .wRaw    (bKeyRaw[k]),
            .wKey    (keyState[k])
        );
    end

    always_comb begin
        rdHitKey = wordHit(bReadAddr, BASEADDR + OFF_KEYSTAT);
        for (int n = 0; n < SEG_WORDS; n++) begin
            wrHit[n] = wordHit(bWriteAddr, BASEADDR + SEG_OFFS[n]);
            rdHit[n] = wordHit(bReadAddr, BASEADDR + SEG_OFFS[n]);
        end
    end

    // Lanes for digits beyond DIGITS stay at zero.
    always_comb begin
        segWords = '0;
        for (int d = 0; d < DIGITS; d++) begin
            segWords[d/4][8*(d%4) +: 8] = segReg[d];
        end
    end

    always_comb begin
        rdWord = '0;
        unique case (1'b1)
            rdHitKey: rdWord[KEYS-1:0] = keyState;
            rdHit[0]: rdWord = segWords[0];
            rdHit[1]: rdWord = segWords[1];
            rdHit[2]: rdWord = segWords[2];
            default:  rdWord = '0;
        endcase
    end

    // Read mux sees pre-write contents on a same-cycle collision.
    always_ff @(posedge wClk or negedge nwReset) begin
        if (!nwReset) begin
            bReadData <= '0;
        end else if (wRead) begin
            bReadData <= rdWord;
        end
    end

    always_ff @(posedge wClk or negedge nwReset) begin
        if (!nwReset) begin
            for (int d = 0; d < DIGITS; d++) begin
                segReg[d] <= SEG_BLANK;
            end
        end else begin
            for (int d = 0; d < DIGITS; d++) begin
                if (wWrite && wrHit[d/4] && !bWriteMask[d%4]) begin
                    segReg[d] <= bWriteData[8*(d%4) +: 8];
                end
            end
        end
    end

    always_ff @(posedge wClk or negedge nwReset) begin
        if (!nwReset) begin
            divCnt   <= '0;
            digitIdx <= '0;
        end else if (divCnt == DIV_LAST) begin
            divCnt <= '0;
            if (digitIdx == IDX_LAST) begin
                digitIdx <= '0;
            end else begin
                digitIdx <= digitIdx + 1'b1;
            end
        end else begin
            divCnt <= divCnt + 1'b1;
        end
    end

    always_ff @(posedge wClk or negedge nwReset) begin
        if (!nwReset) begin
            bSegOut   <= SEG_BLANK;
            bDigitSel <= DIGITS'(1);
        end else begin
            bSegOut   <= segReg[digitIdx];
            bDigitSel <= DIGITS'(1) << digitIdx;
        end
    end

endmodule

// File: tb/tb_seg_key_responder.sv
// Bench for seg_key_responder: directed cases then random bus and
// key traffic, all checked against a behavioural model each cycle.
module tb_seg_key_responder;

    localparam int          KEYS   = 3;
    localparam int          DIGITS = 10;
    localparam int          DEB    = 16;
    localparam int          SDIV   = 4;
    localparam logic [31:0] BASE   = 32'hF000_0000;

    logic              wClk;
    logic              nwReset;
    logic              wWrite;
    logic [31:0]       bWriteAddr;
    logic [31:0]       bWriteData;
    logic [3:0]        bWriteMask;
    logic              wRead;
    logic [31:0]       bReadAddr;
    logic [31:0]       bReadData;
    logic [KEYS-1:0]   bKeyRaw;
    logic [7:0]        bSegOut;
    logic [DIGITS-1:0] bDigitSel;

    int errors;
    int checks;

    seg_key_responder #(
        .KEYS     (KEYS),
        .DIGITS   (DIGITS),
        .BASEADDR (BASE),
        .DEBOUNCE (DEB),
        .SCANDIV  (SDIV)
    ) dut (
        .wClk       (wClk),
        .nwReset    (nwReset),
        .wWrite     (wWrite),
        .bWriteAddr (bWriteAddr),
        .bWriteData (bWriteData),
        .bWriteMask (bWriteMask),
        .wRead      (wRead),
        .bReadAddr  (bReadAddr),
        .bReadData  (bReadData),
        .bKeyRaw    (bKeyRaw),
        .bSegOut    (bSegOut),
        .bDigitSel  (bDigitSel)
    );

    initial wClk = 1'b0;
    always #5 wClk = ~wClk;

    // Behavioural model state
    logic [7:0]        mSeg [12];
    logic [KEYS-1:0]   mAcc;
    logic [KEYS-1:0]   mHist [$];
    logic [31:0]       mRead;
    int                mEdges;
    logic [7:0]        mSegOut;
    logic [DIGITS-1:0] mSel;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mWord(input logic [31:0] a);
        logic [31:0] w;
        logic [31:0] wa;
        w  = 32'h0;
        wa = {a[31:2], 2'b00};
        if (wa == BASE) w[KEYS-1:0] = mAcc;
        for (int n = 0; n < 3; n++) begin
            if (wa == BASE + 32'h10 + 32'(4 * n)) begin
                for (int j = 0; j < 4; j++) begin
                    if (4 * n + j < DIGITS) w[8*j +: 8] = mSeg[4*n+j];
                end
            end
        end
        return w;
    endfunction

    function automatic void modelEdge();
        int  dig;
        bit  allDiff;
        if (!nwReset) begin
            for (int d = 0; d < 12; d++) mSeg[d] = 8'h00;
            mAcc = '0;
            mHist = {};
            for (int i = 0; i < DEB + 2; i++) mHist.push_back('0);
            mRead   = 32'h0;
            mEdges  = 0;
            mSegOut = 8'h00;
            mSel    = DIGITS'(1);
            return;
        end
        mEdges++;
        dig     = ((mEdges - 1) / SDIV) % DIGITS;
        mSegOut = mSeg[dig];
        mSel    = DIGITS'(1) << dig;
        if (wRead) mRead = mWord(bReadAddr);
        // Debouncer sees the raw level from two edges earlier.
        mHist.push_back(bKeyRaw);
        if (mHist.size() > DEB + 2) void'(mHist.pop_front());
        for (int k = 0; k < KEYS; k++) begin
            allDiff = 1'b1;
            for (int u = 0; u < DEB; u++) begin
                if (mHist[u][k] == mAcc[k]) allDiff = 1'b0;
            end
            if (allDiff) mAcc[k] = ~mAcc[k];
        end
        if (wWrite) begin
            for (int n = 0; n < 3; n++) begin
                if ({bWriteAddr[31:2], 2'b00} == BASE + 32'h10 + 32'(4 * n)) begin
                    for (int j = 0; j < 4; j++) begin
                        if (!bWriteMask[j] && (4 * n + j < DIGITS))
                            mSeg[4*n+j] = bWriteData[8*j +: 8];
                    end
                end
            end
        end
    endfunction

    initial begin
        forever begin
            @(posedge wClk);
            modelEdge();
            #1;
            chk("rdata", bReadData, mRead);
            chk("segout", {24'h0, bSegOut}, {24'h0, mSegOut});
            chk("digitsel", 32'(bDigitSel), 32'(mSel));
        end
    end

    // Drive at a negedge, return at the following negedge.
    task automatic bus(input logic w, input logic [31:0] wa,
                       input logic [31:0] wd, input logic [3:0] wm,
                       input logic r, input logic [31:0] ra);
        wWrite     = w;
        bWriteAddr = wa;
        bWriteData = wd;
        bWriteMask = wm;
        wRead      = r;
        bReadAddr  = ra;
        @(posedge wClk);
        @(negedge wClk);
    endtask

    task automatic idle(input int n);
        repeat (n) bus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
    endtask

    task automatic rd(input logic [31:0] ra);
        bus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, ra);
    endtask

    task automatic resetPulse();
        nwReset = 1'b0;
        #1;
        chk("rst_rdata", bReadData, 32'h0);
        chk("rst_segout", {24'h0, bSegOut}, 32'h0);
        chk("rst_digitsel", 32'(bDigitSel), 32'h1);
        @(negedge wClk);
        @(negedge wClk);
        nwReset = 1'b1;
    endtask

    function automatic logic [31:0] pickAddr();
        logic [31:0] a;
        case ($urandom_range(0, 8))
            0: a = BASE;
            1: a = BASE + 32'h10;
            2: a = BASE + 32'h14;
            3: a = BASE + 32'h18;
            4: a = BASE + 32'h04;
            5: a = BASE + 32'h20;
            6: a = $urandom;
            7: a = BASE ^ 32'h1000_0010;
            default: a = BASE + 32'h1C;
        endcase
        return a | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        errors  = 0;
        checks  = 0;
        nwReset = 1'b0;
        wWrite  = 1'b0;
        wRead   = 1'b0;
        bWriteAddr = 32'h0;
        bWriteData = 32'h0;
        bWriteMask = 4'h0;
        bReadAddr  = 32'h0;
        bKeyRaw    = '0;
        repeat (3) @(negedge wClk);
        #1;
        chk("init_rdata", bReadData, 32'h0);
        chk("init_digitsel", 32'(bDigitSel), 32'h1);
        @(negedge wClk);
        nwReset = 1'b1;

        rd(BASE + 32'h10);
        chk("seg0_after_reset", bReadData, 32'h0);

        bus(1'b1, BASE + 32'h18, 32'h0000_6F7F, 4'b1100, 1'b0, 32'h0);
        rd(BASE + 32'h18);
        chk("masked_write", bReadData, 32'h0000_6F7F);
        bus(1'b1, BASE + 32'h18, 32'hFFFF_0000, 4'b0000, 1'b0, 32'h0);
        rd(BASE + 32'h18);
        chk("high_digits_absent", bReadData, 32'h0);

        bus(1'b1, BASE + 32'h10, 32'h4F5B_063F, 4'b0000, 1'b1, BASE + 32'h10);
        chk("same_cycle_old", bReadData, 32'h0);
        rd(BASE + 32'h10);
        chk("read_after_write", bReadData, 32'h4F5B_063F);

        bus(1'b1, BASE + 32'h20, 32'hFFFF_FFFF, 4'b0000, 1'b0, 32'h0);
        rd(BASE + 32'h04);
        chk("unmapped_read", bReadData, 32'h0);
        rd(BASE + 32'h13);
        chk("unmapped_write_seg0", bReadData, 32'h4F5B_063F);
        bus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, BASE + 32'h04);
        chk("read_hold", bReadData, 32'h4F5B_063F);

        idle(7);
        resetPulse();
        rd(BASE + 32'h10);
        chk("seg0_cleared", bReadData, 32'h0);

        resetPulse();
        bus(1'b1, BASE + 32'h10, 32'h4F5B_063F, 4'b0000, 1'b0, 32'h0);
        idle(1);
        chk("scan_d0_seg", {24'h0, bSegOut}, 32'h3F);
        chk("scan_d0_sel", 32'(bDigitSel), 32'h1);
        idle(2);
        chk("scan_d0_last", {24'h0, bSegOut}, 32'h3F);
        idle(1);
        chk("scan_d1_seg", {24'h0, bSegOut}, 32'h06);
        chk("scan_d1_sel", 32'(bDigitSel), 32'h2);
        idle(35);
        chk("scan_d9_sel", 32'(bDigitSel), 32'h200);
        idle(1);
        chk("scan_wrap_sel", 32'(bDigitSel), 32'h1);
        chk("scan_wrap_seg", {24'h0, bSegOut}, 32'h3F);

        bKeyRaw = 3'b010;
        repeat (10) rd(BASE);
        bKeyRaw = 3'b000;
        repeat (25) rd(BASE);
        chk("glitch_rejected", bReadData, 32'h0);
        bKeyRaw = 3'b010;
        for (int i = 1; i <= 20; i++) begin
            rd(BASE);
            if (i == 18) chk("key_not_yet", bReadData, 32'h0);
            if (i == 19) chk("key_accepted", bReadData, 32'h2);
        end
        bKeyRaw = 3'b000;
        repeat (25) rd(BASE);
        chk("key_released", bReadData, 32'h0);

        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < KEYS; k++) begin
                if ($urandom_range(0, 19) == 0) bKeyRaw[k] = ~bKeyRaw[k];
            end
            bus(1'($urandom_range(0, 1)), pickAddr(), $urandom,
                4'($urandom_range(0, 15)), 1'($urandom_range(0, 4) != 0),
                pickAddr());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_key_responder.md
# seg_key_responder

Memory-mapped responder for the board's button/seven-segment peripheral: the target end of the simple write/read bus driven by the counter-display controller. It returns debounced button state at the key-status address and captures byte-masked writes into per-digit segment registers. It scans those registers out one digit at a time to the physical multiplexed display.

## Interface
Parameters:
- `KEYS`, 3: number of push buttons (1..32).
- `DIGITS`, 10: number of seven-segment digits (1..12).
- `BASEADDR`, 32'hF000_0000: peripheral base address.
- `DEBOUNCE`, 16: consecutive stable cycles before a key change is accepted (>=2).
- `SCANDIV`, 1000: clock cycles each digit stays selected (>=2).

Ports (one clock, `wClk`; reset `nwReset` is asynchronous, active-low):
- `wClk`  in  1  system clock, all state on rising edge.
- `nwReset`  in  1  asynchronous active-low reset.
- `wWrite`  in  1  write strobe, one cycle per write.
- `bWriteAddr`  in  32  write byte address.
- `bWriteData`  in  32  write data.
- `bWriteMask`  in  4  per-byte protect mask; bit i = 1 means byte i is NOT written.
- `wRead`  in  1  read strobe (may be held high continuously).
- `bReadAddr`  in  32  read byte address.
- `bReadData`  out  32  read data, registered.
- `bKeyRaw`  in  KEYS  raw asynchronous button inputs, 1 = pressed.
- `bSegOut`  out  8  segment pattern of the selected digit (bit 7 = dp).
- `bDigitSel`  out  DIGITS  one-hot digit select, active-high.

## Operation
- Address map, word-aligned (bits [1:0] ignored, all other bits compared exactly):
  - BASEADDR+0x00 is KEYSTAT (read only): bit i = debounced key i; bits >= KEYS read 0.
  - BASEADDR+0x10, 0x14 and 0x18 are SEG0, SEG1 and SEG2: byte j of SEGn holds the pattern for digit 4n+j.
  - Bytes for digits >= DIGITS are not stored, are not writable, and read 0.
  - Any other address: writes ignored, reads return 0.
- Write: when `wWrite`=1 and the address hits SEGn, each byte with mask bit 0 is stored. Writes to KEYSTAT are ignored.
- Read: when `wRead`=1, `bReadData` is loaded with the addressed word. When `wRead`=0, `bReadData` holds its value.
- Same-cycle read and write to the same word: the read returns the pre-write value.
- Key path: two-flop synchronizer per key, then debounce. The counter resets whenever the synchronized input equals the accepted state. When the input differs for DEBOUNCE consecutive cycles, the accepted state flips and the counter clears.
- Scan: a divider counts 0..SCANDIV-1. On wrap, the digit index advances 0..DIGITS-1 and wraps to 0. `bSegOut` is the register byte for the current index; `bDigitSel` = one-hot(index). Both are registered.
- Reset (mid-operation included) immediately forces:
  - all segment registers to 8'h00;
  - debounced keys, synchronizers, debounce and scan counters to 0;
  - digit index to 0;
  - `bReadData`=0, `bSegOut`=0, `bDigitSel`=one-hot bit 0.

## Timing
- Read latency is 1 cycle: address sampled at edge k, data valid after edge k and held until the next edge with `wRead`=1.
- A write sampled at edge k is visible to a read sampled at edge k+1, and on `bSegOut` at edge k+1 if that digit is selected.
- Key press to KEYSTAT bit: 2 (sync) + DEBOUNCE cycles to the accepted state, plus 1 cycle into `bReadData`. A glitch shorter than DEBOUNCE cycles never appears.
- Each digit is selected for exactly SCANDIV cycles; the full frame is DIGITS*SCANDIV cycles.
- The bus has no wait states and no back-pressure; a new strobe is accepted every cycle.

## Structure
- Package `seg_key_pkg`:
  - address offsets OFF_KEYSTAT=0x00, OFF_SEG0=0x10, OFF_SEG1=0x14, OFF_SEG2=0x18;
  - MAX_DIGITS=12;
  - segment blank constant 8'h00.
- Sub-module `key_debounce`: one instance per key via generate. Ports: clock, reset, raw in, debounced out; parameter DEBOUNCE.
- Top level holds the register file, address decode, read mux and scan divider.

## Test plan
- Reset: assert `nwReset`=0 mid-scan → `bReadData`=0, `bSegOut`=0, `bDigitSel`=1 immediately; a read of SEG0 after release returns 0.
- Masked write: write 0x0000_6F7F to 0xF000_0018 with mask 4'b1100, then read → 0x0000_6F7F. Write 0xFFFF_0000 with mask 4'b0000, then read → 0x0000_0000 when DIGITS=10.
- Full write and read-after-write: write 0x4F5B_063F to 0xF000_0010, mask 0. The same-cycle read returns the old value; the next-cycle read returns 0x4F5B_063F.
- Debounce (DEBOUNCE=16): key1 held high for 10 cycles → KEYSTAT stays 0. Key1 held high for 20 cycles → KEYSTAT=0x2 exactly 18 cycles after the rise plus 1 read cycle.
- Scan (SCANDIV=4, DIGITS=10): digit 0 shows 0x3F for 4 cycles, then digit 1 shows 0x06. Index wraps 9→0 after 40 cycles.
- Unmapped: write to 0xF000_0020 leaves all registers unchanged; reading 0xF000_0004 returns 0.
